// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-8 frame checker: state encoding, CRC width
// and the positions of the init/poly fields inside the 16-bit key.
package crc_pkg;

  localparam int CRC_W        = 8;
  localparam int KEY_INIT_MSB = 15;
  localparam int KEY_INIT_LSB = 8;
  localparam int KEY_POLY_MSB = 7;
  localparam int KEY_POLY_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_BYTE = 2'd2,
    ST_CHECK     = 2'd3
  } state_t;

  function automatic logic [CRC_W-1:0] key_init(input logic [15:0] key);
    return key[KEY_INIT_MSB:KEY_INIT_LSB];
  endfunction

  // The polynomial always carries the x^0 term, so bit 0 is forced high.
  function automatic logic [CRC_W-1:0] key_poly(input logic [15:0] key);
    return key[KEY_POLY_MSB:KEY_POLY_LSB] | {{(CRC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/crc8_serial_engine.sv
// Bit-serial CRC-8 engine: MSB first, one bit per clock, done in the 8th shift cycle.
module crc8_serial_engine
  import crc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             start,
  input  logic [CRC_W-1:0] init,
  input  logic [CRC_W-1:0] poly,
  input  logic [CRC_W-1:0] byte_in,
  output logic [CRC_W-1:0] crc,
  output logic             done
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] d_q;
  logic [2:0]       bit_cnt;
  logic             run;
  logic             fb;
  logic [CRC_W-1:0] crc_next;

  assign fb       = crc_q[CRC_W-1] ^ d_q[CRC_W-1];
  assign crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q   <= '0;
      d_q     <= '0;
      bit_cnt <= '0;
      run     <= 1'b0;
    end else if (start) begin
      d_q     <= byte_in;
      bit_cnt <= '0;
      run     <= 1'b1;
      if (load) crc_q <= init;
    end else if (run) begin
      crc_q   <= crc_next;
      d_q     <= {d_q[CRC_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) run <= 1'b0;
    end
  end

  assign crc  = crc_q;
  assign done = run && (bit_cnt == 3'd7);

endmodule

// File: rtl/crc_frame_checker.sv
// CRC-8 frame checker: FRAME_LEN payload bytes then one CRC byte per frame.
// Optional inter-byte timeout enabled by defining CRC_FRAME_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for the first byte of a frame
// SHIFT        | engine shifting the current byte (8 cycles)
// WAIT_BYTE    | waiting for the next payload byte or the CRC byte
// CHECK        | one cycle: compare received CRC, pulse frame_done
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int FRAME_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic [15:0]      key,
  output logic             payload_valid,
  output logic [7:0]       payload_data,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             overrun_err,
  output logic             busy
`ifdef CRC_FRAME_TIMEOUT_EN
  , output logic           timeout_err
`endif
);

  localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

  state_t           state_q, state_d;
  logic [7:0]       count_q;
  logic [CRC_W-1:0] poly_q;
  logic [CRC_W-1:0] rx_crc_q;
  logic             pv_q;
  logic [7:0]       pd_q;
  logic             ok_q, err_q, ovr_q;
  logic             eng_load, eng_start, eng_done;
  logic [CRC_W-1:0] eng_crc;
  logic             accept_first, accept_payload, accept_crc, overrun, timeout_hit;
  logic             crc_match;

  assign accept_first   = (state_q == ST_IDLE) && rx_valid;
  assign accept_payload = (state_q == ST_WAIT_BYTE) && rx_valid && (count_q < FRAME_LEN_B);
  assign accept_crc     = (state_q == ST_WAIT_BYTE) && rx_valid && (count_q >= FRAME_LEN_B);
  assign overrun        = (state_q == ST_SHIFT) && rx_valid;
  assign crc_match      = (rx_crc_q == eng_crc);

`ifdef CRC_FRAME_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             tout_q;

  // Reloaded on every accepted byte, so the limit is measured from the last
  // rx_valid; it can only fire while waiting for the next byte.
  assign timeout_hit = (state_q == ST_WAIT_BYTE) && !rx_valid && (tmr_q <= TMR_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      tout_q <= timeout_hit;
      if (accept_first || accept_payload || accept_crc)
        tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
      else if (state_q == ST_IDLE || timeout_hit)
        tmr_q <= '0;
      else if (tmr_q != '0)
        tmr_q <= tmr_q - TMR_W'(1);
    end
  end

  assign timeout_err = tout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    eng_load   = 1'b0;
    eng_start  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          eng_load  = 1'b1;
          eng_start = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rx_valid)      state_d = ST_IDLE;
        else if (eng_done) state_d = ST_WAIT_BYTE;
      end
      ST_WAIT_BYTE: begin
        if (accept_payload) begin
          eng_start = 1'b1;
          state_d   = ST_SHIFT;
        end else if (accept_crc) begin
          state_d = ST_CHECK;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      poly_q   <= '0;
      rx_crc_q <= '0;
      pv_q     <= 1'b0;
      pd_q     <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q    <= 1'b0;
      ovr_q   <= overrun;
      if (accept_first) begin
        poly_q  <= key_poly(key);
        count_q <= 8'd1;
        pv_q    <= 1'b1;
        pd_q    <= rx_data;
        ok_q    <= 1'b0;
        err_q   <= 1'b0;
      end
      if (accept_payload) begin
        count_q <= count_q + 8'd1;
        pv_q    <= 1'b1;
        pd_q    <= rx_data;
      end
      if (accept_crc) rx_crc_q <= rx_data;
      if (overrun || timeout_hit) begin
        ok_q  <= 1'b0;
        err_q <= 1'b0;
      end
      if (state_q == ST_CHECK) begin
        ok_q  <= crc_match;
        err_q <= !crc_match;
      end
    end
  end

  crc8_serial_engine u_engine (
    .clk     (clk),
    .reset   (reset),
    .load    (eng_load),
    .start   (eng_start),
    .init    (key_init(key)),
    .poly    (poly_q),
    .byte_in (rx_data),
    .crc     (eng_crc),
    .done    (eng_done)
  );

  // The verdict is visible in the CHECK cycle itself, alongside frame_done.
  assign crc_ok        = (state_q == ST_CHECK) ? crc_match  : ok_q;
  assign crc_err       = (state_q == ST_CHECK) ? !crc_match : err_q;
  assign payload_valid = pv_q;
  assign payload_data  = pd_q;
  assign overrun_err   = ovr_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: instance a has FRAME_LEN=4, instance b FRAME_LEN=9.
// Timeout checks are built only when CRC_FRAME_TIMEOUT_EN is defined.
module tb_crc_frame_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;
  logic [7:0]  rx_data_a = '0, rx_data_b = '0;
  logic [15:0] key_a = '0, key_b = '0;
  logic        payload_valid_a, payload_valid_b;
  logic [7:0]  payload_data_a, payload_data_b;
  logic        frame_done_a, frame_done_b, crc_ok_a, crc_ok_b, crc_err_a, crc_err_b;
  logic        overrun_err_a, overrun_err_b, busy_a, busy_b;
`ifdef CRC_FRAME_TIMEOUT_EN
  logic        timeout_err_a, timeout_err_b;
`endif

  int checks = 0;
  int fails  = 0;
  int pv_cnt_a = 0, pv_cnt_b = 0, fd_cnt_a = 0, fd_cnt_b = 0;
  logic cnt_clr = 1'b0;
  logic [7:0] fb[9];

  always #5 clk = ~clk;

  crc_frame_checker #(.FRAME_LEN(4), .TIMEOUT_CYCLES(50)) dut_a (
    .clk(clk), .reset(reset), .rx_valid(rx_valid_a), .rx_data(rx_data_a), .key(key_a),
    .payload_valid(payload_valid_a), .payload_data(payload_data_a), .frame_done(frame_done_a),
    .crc_ok(crc_ok_a), .crc_err(crc_err_a), .overrun_err(overrun_err_a), .busy(busy_a)
`ifdef CRC_FRAME_TIMEOUT_EN
    , .timeout_err(timeout_err_a)
`endif
  );

  crc_frame_checker #(.FRAME_LEN(9), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid_b), .rx_data(rx_data_b), .key(key_b),
    .payload_valid(payload_valid_b), .payload_data(payload_data_b), .frame_done(frame_done_b),
    .crc_ok(crc_ok_b), .crc_err(crc_err_b), .overrun_err(overrun_err_b), .busy(busy_b)
`ifdef CRC_FRAME_TIMEOUT_EN
    , .timeout_err(timeout_err_b)
`endif
  );

  always @(posedge clk) begin
    if (cnt_clr) begin
      pv_cnt_a <= 0; pv_cnt_b <= 0; fd_cnt_a <= 0; fd_cnt_b <= 0;
    end else begin
      if (payload_valid_a) pv_cnt_a <= pv_cnt_a + 1;
      if (payload_valid_b) pv_cnt_b <= pv_cnt_b + 1;
      if (frame_done_a)    fd_cnt_a <= fd_cnt_a + 1;
      if (frame_done_b)    fd_cnt_b <= fd_cnt_b + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // Presents one byte for one cycle; returns one cycle after the strobe was sampled.
  task automatic send(input int which, input logic [7:0] d);
    if (which == 0) begin rx_valid_a = 1'b1; rx_data_a = d; end
    else            begin rx_valid_b = 1'b1; rx_data_b = d; end
    tick();
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
  endtask

  task automatic do_frame(input int which, input int n, input logic [7:0] crc_byte,
                          input logic [15:0] k0, input logic [15:0] k1,
                          input bit exp_ok, input string tag);
    if (which == 0) key_a = k0; else key_b = k0;
    clear_counts();
    for (int i = 0; i < n; i++) begin
      send(which, fb[i]);
      check({tag, " payload_data"}, (which == 0) ? payload_data_a : payload_data_b, fb[i]);
      if (i == 0) begin
        if (which == 0) key_a = k1; else key_b = k1;
      end
      repeat (8) tick();
    end
    send(which, crc_byte);
    check({tag, " frame_done"}, (which == 0) ? frame_done_a : frame_done_b, 1);
    check({tag, " crc_ok"},     (which == 0) ? crc_ok_a : crc_ok_b, exp_ok);
    check({tag, " crc_err"},    (which == 0) ? crc_err_a : crc_err_b, !exp_ok);
    check({tag, " payload_valid on crc"}, (which == 0) ? payload_valid_a : payload_valid_b, 0);
    tick();
    check({tag, " frame_done low"}, (which == 0) ? frame_done_a : frame_done_b, 0);
    check({tag, " busy after"},     (which == 0) ? busy_a : busy_b, 0);
    check({tag, " verdict held"},   (which == 0) ? crc_ok_a : crc_ok_b, exp_ok);
    check({tag, " payload count"},  (which == 0) ? pv_cnt_a : pv_cnt_b, n);
    check({tag, " frame_done count"}, (which == 0) ? fd_cnt_a : fd_cnt_b, 1);
  endtask

  task automatic load_abcd();
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
  endtask

  initial begin
    tick();
    tick();
    check("reset busy_a", busy_a, 0);
    check("reset pv_a", payload_valid_a, 0);
    check("reset ok_a", crc_ok_a, 0);
    check("reset err_b", crc_err_b, 0);
    check("reset ovr_a", overrun_err_a, 0);
    reset = 1'b0;
    tick();

    // "123456789" with CRC-8 poly 0x07 init 0x00 -> 0xF4
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    do_frame(1, 9, 8'hF4, 16'h0007, 16'h0007, 1'b1, "good9");
    do_frame(1, 9, 8'hF5, 16'h0007, 16'h0007, 1'b0, "bad9");

    // 01 02 03 04 with poly 0x07 init 0x00 -> 0xE3
    load_abcd();
    do_frame(0, 4, 8'hE3, 16'h0007, 16'h0007, 1'b1, "good4");

    // init 0xFF, poly field 0x06 (bit 0 forced -> 0x07): FF 01 02 03 -> 0x48
    fb[0] = 8'hFF; fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03;
    do_frame(0, 4, 8'h48, 16'hFF06, 16'hFF06, 1'b1, "init_poly");

    load_abcd();
    do_frame(0, 4, 8'hE3, 16'h0007, 16'hFF31, 1'b1, "key_latch");

    // Overrun: second strobe 3 cycles after the first lands in SHIFT
    key_a = 16'h0007;
    clear_counts();
    send(0, 8'h01);
    tick();
    tick();
    send(0, 8'hAA);
    check("ovr pulse", overrun_err_a, 1);
    check("ovr busy", busy_a, 0);
    check("ovr frame_done", frame_done_a, 0);
    check("ovr crc_ok", crc_ok_a, 0);
    tick();
    check("ovr pulse width", overrun_err_a, 0);
    check("ovr payload count", pv_cnt_a, 1);
    check("ovr frame_done count", fd_cnt_a, 0);
    load_abcd();
    do_frame(0, 4, 8'hE3, 16'h0007, 16'h0007, 1'b1, "after_ovr");

    // Reset mid-frame, also clears the held crc_err of instance b
    check("b err still held", crc_err_b, 1);
    send(0, 8'h01);
    repeat (8) tick();
    send(0, 8'h02);
    check("pre-reset pv", payload_valid_a, 1);
    reset = 1'b1;
    tick();
    check("rst busy", busy_a, 0);
    check("rst pv", payload_valid_a, 0);
    check("rst pdata", payload_data_a, 0);
    check("rst frame_done", frame_done_a, 0);
    check("rst crc_ok", crc_ok_a, 0);
    check("rst overrun", overrun_err_a, 0);
    check("rst b crc_err", crc_err_b, 0);
    reset = 1'b0;
    tick();
    load_abcd();
    do_frame(0, 4, 8'hE3, 16'h0007, 16'h0007, 1'b1, "after_rst");

`ifdef CRC_FRAME_TIMEOUT_EN
    key_a = 16'h0007;
    clear_counts();
    send(0, 8'h01);
    repeat (48) tick();
    check("tmo early", timeout_err_a, 0);
    check("tmo busy early", busy_a, 1);
    tick();
    check("tmo pulse", timeout_err_a, 1);
    check("tmo busy", busy_a, 0);
    tick();
    check("tmo pulse width", timeout_err_a, 0);
    check("tmo frame_done count", fd_cnt_a, 0);
    load_abcd();
    do_frame(0, 4, 8'hE3, 16'h0007, 16'h0007, 1'b1, "after_tmo");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
